booth_mul_seq: RTL

- Iterative radix-2 Booth signed multiplier for the KGP RISC ALU. Computes a 32x32 to 64-bit signed product over 32 cycles.
- Sits directly downstream of the team's 32-bit two's-complement negator. The negator's output (-A) is consumed as the subtract operand, so the block contains no negation logic of its own.
- The core uses the 64-bit product as {HI, LO} for the MUL instruction.

---
 rtl/booth_mul_seq.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: iterative radix-2 Booth signed multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One Booth step per clock, WIDTH steps per product. The subtract operand (-A)
// comes from the upstream two's-complement negator, so no negation logic lives here.
// Optional build macro BOOTH_MUL_OVF_FLAG_EN adds the OVF output (product does not
// fit in a WIDTH-bit signed value).
module booth_mul_seq #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] MCAND,
   input  logic [WIDTH-1:0] MCAND_NEG,
   input  logic [WIDTH-1:0] MPLIER,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] PROD_HI,
   output logic [WIDTH-1:0] PROD_LO
`ifdef BOOTH_MUL_OVF_FLAG_EN
   ,
   output logic             OVF
`endif
);

   localparam int AW = 2 * WIDTH + 2;          // accumulator: 33-bit upper half + multiplier + Booth bit
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [AW-1:0]    acc_r;
   logic [WIDTH:0]   m_r;
   logic [WIDTH:0]   mn_r;
   logic [CW-1:0]    cnt_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] prod_hi_r;
   logic [WIDTH-1:0] prod_lo_r;
`ifdef BOOTH_MUL_OVF_FLAG_EN
   logic             ovf_r;
`endif

   logic [WIDTH:0]   sum_s;
   logic [AW-1:0]    acc_next_s;
   logic [AW-1:0]    acc_load_s;
   logic [WIDTH:0]   m_load_s;
   logic [WIDTH:0]   mn_load_s;

   // Operand capture values: -A gets its sign bit fixed up so that A = most-negative yields +2^(WIDTH-1).
   always_comb begin
      acc_load_s = {{(WIDTH+1){1'b0}}, MPLIER, 1'b0};
      m_load_s   = {MCAND[WIDTH-1], MCAND};
      if (MCAND == MOST_NEG) begin
         mn_load_s = {~MCAND_NEG[WIDTH-1], MCAND_NEG};
      end else begin
         mn_load_s = {MCAND_NEG[WIDTH-1], MCAND_NEG};
      end
   end

   // One Booth step: conditional add of +A / -A into the upper half, then arithmetic shift right.
   always_comb begin
      sum_s = acc_r[AW-1:WIDTH+1];
      case (acc_r[1:0])
         2'b01:   sum_s = acc_r[AW-1:WIDTH+1] + m_r;
         2'b10:   sum_s = acc_r[AW-1:WIDTH+1] + mn_r;
         default: sum_s = acc_r[AW-1:WIDTH+1];
      endcase
      acc_next_s = {sum_s[WIDTH], sum_s, acc_r[WIDTH:1]};
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r   <= ST_IDLE;
         acc_r     <= {AW{1'b0}};
         m_r       <= {(WIDTH+1){1'b0}};
         mn_r      <= {(WIDTH+1){1'b0}};
         cnt_r     <= {CW{1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         prod_hi_r <= {WIDTH{1'b0}};
         prod_lo_r <= {WIDTH{1'b0}};
`ifdef BOOTH_MUL_OVF_FLAG_EN
         ovf_r     <= 1'b0;
`endif
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (START) begin
                  acc_r   <= acc_load_s;
                  m_r     <= m_load_s;
                  mn_r    <= mn_load_s;
                  cnt_r   <= {CW{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               // START is deliberately not looked at here: requests during a multiply are dropped.
               acc_r <= acc_next_s;
               cnt_r <= cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) begin
                  busy_r  <= 1'b0;
                  state_r <= ST_DONE;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_DONE: begin
               done_r    <= 1'b1;
               prod_hi_r <= acc_r[2*WIDTH:WIDTH+1];
               prod_lo_r <= acc_r[WIDTH:1];
`ifdef BOOTH_MUL_OVF_FLAG_EN
               ovf_r     <= (acc_r[2*WIDTH:WIDTH+1] != {WIDTH{acc_r[WIDTH]}});
`endif
               if (START) begin
                  acc_r   <= acc_load_s;
                  m_r     <= m_load_s;
                  mn_r    <= mn_load_s;
                  cnt_r   <= {CW{1'b0}};
                  busy_r  <= 1'b1;
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign BUSY    = busy_r;
   assign DONE    = done_r;
   assign PROD_HI = prod_hi_r;
   assign PROD_LO = prod_lo_r;
`ifdef BOOTH_MUL_OVF_FLAG_EN
   assign OVF     = ovf_r;
`endif

endmodule
